// File: rtl/inst_fetch_queue.sv
// Instruction queue between IF and ID: a DEPTH-entry circular buffer holding
// {pc, inst, exception info}, with a valid/ready handshake on both sides and a redirect flush.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       inst_sram_rdata,
  input  logic              in_exc,
  input  logic [5:0]        in_ecode,
  input  logic [8:0]        in_esubcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic              out_exc,
  output logic [5:0]        out_ecode,
  output logic [8:0]        out_esubcode,
  output logic [PTR_W:0]    count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
  } entry_t;

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  entry_t           wr_entry;
  entry_t           head;

  // in_ready depends only on registered occupancy and flush, never on out_ready.
  assign in_ready  = (count != FULL) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_entry          = '0;
    wr_entry.pc       = in_pc;
    // A faulting fetch never carries SRAM data downstream.
    wr_entry.inst     = in_exc ? 32'h0 : inst_sram_rdata;
    wr_entry.exc      = in_exc;
    wr_entry.ecode    = in_ecode;
    wr_entry.esubcode = in_esubcode;
  end

  // NOTE: the storage array has no reset; only pointers and count define validity,
  // so resetting the entries would add logic without changing behaviour.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head         = mem[rd_ptr];
  assign out_pc       = head.pc;
  assign out_inst     = head.inst;
  assign out_exc      = head.exc;
  assign out_ecode    = head.ecode;
  assign out_esubcode = head.esubcode;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a table of directed cycles, hand-written
// exception/reset sequences and a random phase, with a scoreboard of queued entries.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] inst_sram_rdata;
  logic        in_exc;
  logic [5:0]  in_ecode;
  logic [8:0]  in_esubcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_exc;
  logic [5:0]  out_ecode;
  logic [8:0]  out_esubcode;
  logic [2:0]  count;

  inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .inst_sram_rdata(inst_sram_rdata), .in_exc(in_exc), .in_ecode(in_ecode),
    .in_esubcode(in_esubcode), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc), .out_ecode(out_ecode),
    .out_esubcode(out_esubcode), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
  } entry_t;

  typedef struct packed {
    logic       fl;
    logic       iv;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [2:0] e_cnt;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          model_count = 0;
  logic [31:0] next_pc = 32'h1c00_0000;
  entry_t      sb[$];
  vec_t        vecs[22];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_for(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  // One clock cycle: drive at posedge+1, check at the negedge, update the model, advance.
  task automatic cycle(input logic fl, input logic iv, input logic ordy,
                       input logic ex, input logic [5:0] ec, input logic [8:0] es,
                       input logic [31:0] rd,
                       input logic e_ir, input logic e_ov, input logic [2:0] e_cnt);
    entry_t e;
    logic   do_push;
    logic   do_pop;
    flush = fl; in_valid = iv; out_ready = ordy; in_pc = next_pc;
    inst_sram_rdata = rd; in_exc = ex; in_ecode = ec; in_esubcode = es;
    #4;
    check("in_ready", 80'(in_ready), 80'(e_ir));
    check("out_valid", 80'(out_valid), 80'(e_ov));
    check("count", 80'(count), 80'(e_cnt));
    if (model_count != 0) begin
      if (sb.size() == 0) check("scoreboard_empty", 80'(1), 80'(0));
      else check("head", {out_pc, out_inst, out_exc, out_ecode, out_esubcode}, sb[0]);
    end
    do_push = iv && (model_count != DEPTH) && !fl;
    do_pop  = (model_count != 0) && ordy && !fl;
    if (fl) begin
      sb.delete();
      model_count = 0;
    end else begin
      if (do_pop && sb.size() != 0) void'(sb.pop_front());
      if (do_push) begin
        e = '{pc: next_pc, inst: (ex ? 32'h0 : rd), exc: ex, ecode: ec, esubcode: es};
        sb.push_back(e);
        next_pc = next_pc + 32'd4;
      end
      model_count = model_count + int'(do_push) - int'(do_pop);
    end
    @(posedge clk); #1;
  endtask

  task automatic plain(input logic fl, input logic iv, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [2:0] e_cnt);
    cycle(fl, iv, ordy, 1'b0, 6'h0, 9'h0, word_for(next_pc), e_ir, e_ov, e_cnt);
  endtask

  initial begin
    //            fl iv or ir ov cnt
    vecs = '{
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0},  // fill to full with ID stalled
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1},
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2},
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4},  // full: push refused
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4},  // pop while full, no same-cycle push
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3},  // push+pop, pointers wrap
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3},  // drain
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0},  // empty: out_ready ignored
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0},  // steady stream
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1},
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1},  // build to 3
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3},  // flush beats push and pop
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0}
    };

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0;
    inst_sram_rdata = '0; in_exc = 1'b0; in_ecode = '0; in_esubcode = '0;
    #3;
    check("reset_in_ready", 80'(in_ready), 80'(1));
    check("reset_out_valid", 80'(out_valid), 80'(0));
    check("reset_count", 80'(count), 80'(0));
    #9 rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      plain(vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_cnt);

    // Faulting fetch: SRAM data must be replaced by zero.
    next_pc = 32'h1c00_0002;
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 6'h8, 9'h0, 32'hdead_beef, 1'b1, 1'b0, 3'd0);
    check("exc_out_exc", 80'(out_exc), 80'(1));
    check("exc_out_ecode", 80'(out_ecode), 80'(6'h8));
    check("exc_out_inst", 80'(out_inst), 80'(0));
    check("exc_out_pc", 80'(out_pc), 80'(32'h1c00_0002));
    plain(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1);

    // Asynchronous reset mid-cycle with two entries queued.
    plain(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    plain(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    check("pre_reset_count", 80'(count), 80'(2));
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", 80'(out_valid), 80'(0));
    check("async_in_ready", 80'(in_ready), 80'(1));
    check("async_count", 80'(count), 80'(0));
    #1 rst = 1'b1;
    sb.delete();
    model_count = 0;
    @(posedge clk); #1;
    plain(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      logic fl, iv, ordy, ex;
      fl   = ($urandom_range(15) == 0);
      iv   = ($urandom_range(3) != 0);
      ordy = ($urandom_range(2) != 0);
      ex   = ($urandom_range(7) == 0);
      cycle(fl, iv, ordy, ex, 6'($urandom), 9'($urandom), $urandom,
            (model_count != DEPTH) && !fl, model_count != 0, 3'(model_count));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
